// File: rtl/line_buf_pkg.sv
// Shared defaults and helpers for the multi-line pixel buffer.
package line_buf_pkg;

  localparam int LB_DATA_W   = 8;
  localparam int LB_H_ACTIVE = 720;

  typedef logic [LB_DATA_W-1:0] pixel_t;

  // Ring slot holding the line that is k lines older than the one in slot wr_line.
  function automatic int tap_slot(input int wr_line, input int k, input int n);
    return (wr_line - k + n) % n;
  endfunction

endpackage

// File: rtl/lb_ram_rf.sv
// Single-clock line store, one write and one read port, read-first on address collision.
module lb_ram_rf #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 720,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  (* ram_style = "block" *) logic [DATA_W-1:0] mem [DEPTH];

  // Both accesses use non-blocking updates, so a same-address read sees the old word.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/line_buffer_taps.sv
// Ring of NUM_LINES line stores producing NUM_LINES+1 column-aligned vertical taps per pixel.
module line_buffer_taps
  import line_buf_pkg::*;
#(
  parameter int DATA_W    = LB_DATA_W,
  parameter int H_ACTIVE  = LB_H_ACTIVE,
  parameter int NUM_LINES = 2,
  parameter int ADDR_W    = $clog2(H_ACTIVE)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [DATA_W-1:0]               in_data,
  input  logic                            in_sof,
  input  logic                            in_eol,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [(NUM_LINES+1)*DATA_W-1:0] out_taps,
  output logic [NUM_LINES:0]              out_tap_ok,
  output logic [ADDR_W-1:0]               out_col,
  output logic                            out_sof,
  output logic                            out_eol,
  output logic                            line_err
);

  localparam int LW = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1;
  localparam int FW = $clog2(NUM_LINES + 1);
  localparam int NT = NUM_LINES + 1;

  // Handshake: a beat moves when valid && ready; valid never drops and payload never
  // changes while the beat waits for ready. One output register stage, so the input
  // is ready whenever that register is empty or being emptied this cycle.
  logic              acc;
  logic [ADDR_W-1:0] col, ec;
  logic [LW-1:0]     wr_line, wr_line_q;
  logic [FW-1:0]     fill, ef;
  logic              at_last, eol_eff, err_now;
  logic [DATA_W-1:0] rd_data [NUM_LINES];
  logic [DATA_W-1:0] tap0_q;
  logic [NT*DATA_W-1:0] taps_mux;
  logic [NT-1:0]     tap_ok_next;

  assign in_ready = !out_valid || out_ready;
  assign acc      = in_valid && in_ready;
  assign ec       = in_sof ? '0 : col;
  assign ef       = in_sof ? '0 : fill;
  assign at_last  = (ec == ADDR_W'(H_ACTIVE - 1));
  assign eol_eff  = in_eol || at_last;
  // Short line (eol before the last column) or overrun (last column without eol).
  assign err_now  = in_eol != at_last;

  for (genvar g = 0; g < NUM_LINES; g++) begin : g_line
    lb_ram_rf #(
      .DATA_W (DATA_W),
      .DEPTH  (H_ACTIVE),
      .ADDR_W (ADDR_W)
    ) u_ram (
      .clk   (clk),
      .we    (acc && (wr_line == LW'(g))),
      .waddr (ec),
      .wdata (in_data),
      .re    (acc),
      .raddr (ec),
      .rdata (rd_data[g])
    );
  end

  always_comb begin
    tap_ok_next = '0;
    for (int k = 0; k <= NUM_LINES; k++) tap_ok_next[k] = (k <= int'(ef));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col     <= '0;
      wr_line <= '0;
      fill    <= '0;
    end else if (acc) begin
      if (eol_eff) begin
        col     <= '0;
        wr_line <= (wr_line == LW'(NUM_LINES - 1)) ? '0 : wr_line + 1'b1;
        fill    <= (ef == FW'(NUM_LINES)) ? ef : ef + 1'b1;
      end else begin
        col  <= ec + 1'b1;
        fill <= ef;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      tap0_q     <= '0;
      wr_line_q  <= '0;
      out_tap_ok <= '0;
      out_col    <= '0;
      out_sof    <= 1'b0;
      out_eol    <= 1'b0;
      line_err   <= 1'b0;
    end else begin
      line_err <= acc && err_now;
      if (acc) begin
        out_valid  <= 1'b1;
        tap0_q     <= in_data;
        wr_line_q  <= wr_line;
        out_tap_ok <= tap_ok_next;
        out_col    <= ec;
        out_sof    <= in_sof;
        out_eol    <= eol_eff;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  // RAM read data is already registered, so tap0 is registered to sit beside it.
  always_comb begin
    taps_mux = '0;
    taps_mux[0 +: DATA_W] = tap0_q;
    for (int k = 1; k <= NUM_LINES; k++)
      taps_mux[k*DATA_W +: DATA_W] = rd_data[LW'(tap_slot(int'(wr_line_q), k, NUM_LINES))];
  end

  assign out_taps = out_valid ? taps_mux : '0;

endmodule

// File: tb/tb_line_buffer_taps.sv
// Scoreboard bench for line_buffer_taps with default parameters (8-bit, 720 columns, 2 history lines).
module tb_line_buffer_taps;

  localparam int EW = 40;  // {taps[23:0], ok[2:0], col[9:0], sof, eol, err}

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_data = '0;
  logic        in_sof = 1'b0;
  logic        in_eol = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [23:0] out_taps;
  logic [2:0]  out_tap_ok;
  logic [9:0]  out_col;
  logic        out_sof;
  logic        out_eol;
  logic        line_err;

  int total = 0;
  int bad = 0;
  logic bp_en = 1'b0;

  logic [EW-1:0] exp_q[$];

  line_buffer_taps dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_sof     (in_sof),
    .in_eol     (in_eol),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_taps   (out_taps),
    .out_tap_ok (out_tap_ok),
    .out_col    (out_col),
    .out_sof    (out_sof),
    .out_eol    (out_eol),
    .line_err   (line_err)
  );

  // clock / back-pressure
  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    out_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // reference model of the raster position and stored history
  int m_col = 0;
  int m_line = 0;
  logic [7:0] hist[int];

  task automatic model_reset();
    m_col = 0;
    m_line = 0;
    hist.delete();
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // driver
  task automatic send_pix(input logic [7:0] d, input logic sof, input logic eol);
    logic [23:0] et;
    logic [2:0]  eok;
    logic        eol_e, err_e, accepted;
    int key, n;
    if (sof) model_reset();
    eol_e = eol || (m_col == 719);
    err_e = (eol && m_col < 719) || (!eol && m_col == 719);
    et = '0;
    et[7:0] = d;
    eok = 3'b001;
    for (int k = 1; k <= 2; k++) begin
      if (k <= m_line) begin
        eok[k] = 1'b1;
        key = (m_line - k) * 1024 + m_col;
        if (hist.exists(key)) et[k*8 +: 8] = hist[key];
      end
    end
    hist[m_line * 1024 + m_col] = d;
    exp_q.push_back({et, eok, 10'(m_col), sof, eol_e, err_e});
    if (eol_e) begin
      m_col = 0;
      m_line++;
    end else begin
      m_col++;
    end
    in_valid = 1'b1;
    in_data  = d;
    in_sof   = sof;
    in_eol   = eol;
    n = 0;
    accepted = 1'b0;
    while (!accepted && n < 2000) begin
      @(negedge clk);
      accepted = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!accepted) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: got in_ready=0, expected 1 within 2000 cycles");
    end
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_sof = 1'b0;
    in_eol = 1'b0;
  endtask

  task automatic drain();
    idle();
    bp_en = 1'b0;
    for (int i = 0; i < 5000 && (exp_q.size() != 0 || out_valid); i++) @(posedge clk);
    #1;
    check("drain_queue_empty", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_out_taps"}, 32'(out_taps), 32'd0);
    check({tag, "_out_tap_ok"}, 32'(out_tap_ok), 32'd0);
    check({tag, "_out_col"}, 32'(out_col), 32'd0);
    check({tag, "_out_sof"}, 32'(out_sof), 32'd0);
    check({tag, "_out_eol"}, 32'(out_eol), 32'd0);
    check({tag, "_line_err"}, 32'(line_err), 32'd0);
  endtask

  // scoreboard monitor
  logic prev_v = 1'b0;
  logic prev_hs = 1'b0;
  logic beat_err = 1'b0;
  logic [38:0] held;

  always @(negedge clk) begin
    logic [EW-1:0] e;
    logic mis;
    if (rst) begin
      prev_v = 1'b0;
      prev_hs = 1'b0;
    end else begin
      if (out_valid) begin
        if (!prev_v || prev_hs) begin
          beat_err = line_err;
        end else begin
          total++;
          if ({out_taps, out_tap_ok, out_col, out_sof, out_eol} !== held) begin
            bad++;
            $display("FAIL stall_hold: got %h, expected %h", {out_taps, out_tap_ok, out_col, out_sof, out_eol}, held);
          end
        end
        held = {out_taps, out_tap_ok, out_col, out_sof, out_eol};
        if (out_ready) begin
          total++;
          if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_beat: got col=%0d with empty expected queue", out_col);
          end else begin
            e = exp_q.pop_front();
            mis = (out_tap_ok !== e[15:13]) || (out_col !== e[12:3]) || (out_sof !== e[2])
                  || (out_eol !== e[1]) || (beat_err !== e[0]);
            for (int k = 0; k < 3; k++)
              if (e[13+k] && out_taps[k*8 +: 8] !== e[16+k*8 +: 8]) mis = 1'b1;
            if (mis) begin
              bad++;
              $display("FAIL beat: got taps=%h ok=%b col=%0d sof=%b eol=%b err=%b, expected taps=%h ok=%b col=%0d sof=%b eol=%b err=%b",
                       out_taps, out_tap_ok, out_col, out_sof, out_eol, beat_err,
                       e[39:16], e[15:13], e[12:3], e[2], e[1], e[0]);
            end
          end
        end
      end
      prev_v = out_valid;
      prev_hs = out_valid && out_ready;
    end
  end

  // stimulus
  initial begin
    #3;
    check_outputs_zero("reset");
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // three full lines, pixel = line*16 + col[3:0]
    for (int l = 0; l < 3; l++)
      for (int c = 0; c < 720; c++)
        send_pix(8'(l * 16 + (c & 15)), (l == 0 && c == 0), (c == 719));
    drain();

    // four lines under random back-pressure
    bp_en = 1'b1;
    for (int l = 0; l < 4; l++)
      for (int c = 0; c < 720; c++)
        send_pix(8'((l * 16 + (c & 15)) ^ 8'h80), (l == 0 && c == 0), (c == 719));
    drain();

    // short lines of 100 pixels
    for (int l = 0; l < 3; l++)
      for (int c = 0; c < 100; c++)
        send_pix(8'($urandom_range(0, 255)), (l == 0 && c == 0), (c == 99));
    drain();

    // overrun: 725 pixels without eol, continue to col 299, then sof mid-line
    for (int c = 0; c < 1020; c++)
      send_pix(8'($urandom_range(0, 255)), (c == 0), 1'b0);
    for (int c = 0; c < 4; c++)
      send_pix(8'($urandom_range(0, 255)), (c == 0), 1'b0);
    drain();

    // asynchronous reset in the middle of a line
    for (int c = 0; c < 50; c++)
      send_pix(8'($urandom_range(0, 255)), (c == 0), 1'b0);
    drain();
    #2;
    rst = 1'b1;
    #1;
    check_outputs_zero("midline_reset");
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    for (int c = 0; c < 8; c++)
      send_pix(8'($urandom_range(0, 255)), 1'b0, 1'b0);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/line_buffer_taps.md
Name: line_buffer_taps

Overview:
- Single-clock, parametrised multi-line buffer for the pixel-clock domain. Feeds the vertical filter and BOB deinterlace stages.
- Accepts a raster pixel stream with valid/ready and stores the last NUM_LINES lines in a ring of block-RAM line stores.
- For every accepted pixel, emits NUM_LINES+1 column-aligned vertical taps (current line plus NUM_LINES previous lines), each with a per-tap history-valid flag.
- Generalises the dual-clock 8-bit/720 line buffer in width, depth and line count, and adds flow control, frame/line framing and line-length error handling.

Parameters:
- DATA_W, 8, pixel width in bits.
- H_ACTIVE, 720, maximum pixels per line (RAM depth).
- NUM_LINES, 2, stored history lines (≥1); output tap count is NUM_LINES+1.
- ADDR_W, $clog2(H_ACTIVE), column address width (derived, do not override).

Ports:
- clk  in  1  pixel clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input pixel valid.
- in_ready  out  1  input accepted when in_valid && in_ready.
- in_data  in  DATA_W  input pixel.
- in_sof  in  1  first pixel of frame (qualified by handshake).
- in_eol  in  1  last pixel of line (qualified by handshake).
- out_valid  out  1  output taps valid.
- out_ready  in  1  downstream accept.
- out_taps  out  (NUM_LINES+1)*DATA_W  tap k at bits [k*DATA_W +: DATA_W]; k=0 current line, k=n is line minus n.
- out_tap_ok  out  NUM_LINES+1  bit k=1 when tap k holds real history from this frame.
- out_col  out  ADDR_W  column of the emitted pixel.
- out_sof  out  1  passthrough of in_sof, aligned with the taps.
- out_eol  out  1  passthrough of in_eol (or implicit EOL), aligned with the taps.
- line_err  out  1  one-cycle pulse: line overrun or short line detected.

Behaviour:
- Reset:
  - out_valid, out_taps, out_tap_ok, out_col, out_sof, out_eol and line_err all 0.
  - Internal col=0, wr_line=0, fill=0.
  - RAM contents are not reset.
- Flow control:
  - in_ready = !out_valid || out_ready. This is a single output register stage; no bubbles when the output is not stalled.
  - When stalled (out_valid && !out_ready), all outputs hold and RAMs are not written.
- Latency: exactly 1 cycle from input acceptance to out_valid.
- Per accepted pixel (acc = in_valid && in_ready):
  - Effective column ec = in_sof ? 0 : col. Effective fill ef = in_sof ? 0 : fill.
  - Read all NUM_LINES RAMs at ec.
  - Write in_data to RAM[wr_line] at ec in the same cycle. That RAM must be read-first: tap NUM_LINES returns the old line, not in_data.
  - Tap mapping:
    - tap0 = in_data, registered.
    - tap k = RAM[(wr_line - k + NUM_LINES) mod NUM_LINES] for k = 1..NUM_LINES, taken from the read output.
    - Registered tap0 must align with the RAM read data.
  - out_tap_ok[0] = 1. out_tap_ok[k] = (k ≤ ef).
- Line end (in_eol, or implicit EOL):
  - col ← 0.
  - wr_line ← (wr_line+1) mod NUM_LINES.
  - fill ← min(ef+1, NUM_LINES).
- Otherwise: col ← ec+1.
- in_sof:
  - col and fill are treated as 0 for that pixel.
  - wr_line is unchanged (any ring slot is valid as the start).
- Implicit EOL (overrun): ec == H_ACTIVE-1 without in_eol.
  - Treated as EOL and out_eol=1.
  - line_err pulses with the output.
- Short line: in_eol with ec < H_ACTIVE-1.
  - Legal; line_err pulses.
  - Columns above ec keep stale data and are never read while lines have the same length.
- Simultaneous in_sof and in_eol (1-pixel line): the pixel is written at col 0 and the line advances.
- Reset mid-line: abandons the line. The first pixel after reset without in_sof is treated as col 0 with fill=0.

Decomposition:
- Package line_buf_pkg holds the default constants (DATA_W, H_ACTIVE) and a tap-index helper function. No typedefs beyond a pixel type.
- Sub-module lb_ram_rf: single-clock, one write port and one read port, read-first, DATA_W×H_ACTIVE, block-RAM style attribute. Instantiated NUM_LINES times through a generate loop.

Test Plan:
- Reset, then 3 lines of 720 pixels with pixel = line*16+col[3:0], NUM_LINES=2.
  - Line 0: tap_ok=3'b001.
  - Line 1: tap_ok=3'b011, tap1 = line-0 value.
  - Line 2 col 5: taps = {0x05, 0x15, 0x25} (tap2, tap1, tap0), tap_ok=3'b111.
- Read-first check: line 2 overwrites slot 0. tap2 at each column equals the line-0 data, never the new data.
- Random out_ready back-pressure (~50%) over 4 lines: no lost or duplicated pixels, out_col sequence 0..719 per line, outputs stable while stalled.
- Overrun: 725 pixels without in_eol.
  - line_err pulses and out_eol=1 at col 719.
  - Pixel 721 is emitted at col 0 of the next line.
- Short line: in_eol at col 99 → line_err pulse. The next line's tap1 at col 0..99 equals the short-line data.
- in_sof mid-frame at col 300 (plus async rst mid-line): col restarts at 0, tap_ok=3'b001, and all outputs are 0 during rst.
